vrf_wb_arbiter: RTL and testbench

Per-lane write-back arbiter. It shares one VRF write port between the external result producers: load unit (src 0), slide unit (src 1) and mask unit (src 2). Sits inside each lane, in front of the VRF bank request path. It replaces the ad-hoc per-source gnt logic with a round-robin scheduler and a one-entry output register.

---
 rtl/vrf_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_vrf_wb_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vrf_wb_arbiter.sv
// vrf_wb_arbiter
//   Per-lane write-back arbiter. It shares one VRF write port between the
//   load unit (src 0), slide unit (src 1) and mask unit (src 2). A round-robin
//   scheduler picks one requester per cycle into a one-entry output register.
//   The register can drain and refill in the same cycle, so throughput is one
//   write per cycle.
//
// Ports
//   clk_i, rst_i        clock, async active-high reset
//   src_req_i           per-source write request (held until granted)
//   src_addr/id/wdata/be_i  per-source write fields, packed by source index
//   src_gnt_o           one-hot single-cycle grant (comb)
//   vrf_req_o, vrf_addr/id/wdata/be_o  registered VRF write request
//   vrf_gnt_i           VRF accepts the current request
//   flush_i             drop the buffered write, suppress grants this cycle
//
// Optional build macro ARA_WB_ARB_PERF_EN
//   perf_grant_cnt_o    saturating 32-bit grant counter per source
//   perf_stall_cnt_o    saturating count of cycles with full & !vrf_gnt_i
module vrf_wb_arbiter #(
  parameter int NrSrc     = 3,
  parameter int AddrWidth = 10,
  parameter int DataWidth = 64,
  parameter int IdWidth   = 3,
  parameter int StrbWidth = DataWidth/8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrSrc-1:0]               src_req_i,
  input  logic [NrSrc*AddrWidth-1:0]     src_addr_i,
  input  logic [NrSrc*IdWidth-1:0]       src_id_i,
  input  logic [NrSrc*DataWidth-1:0]     src_wdata_i,
  input  logic [NrSrc*StrbWidth-1:0]     src_be_i,
  output logic [NrSrc-1:0]               src_gnt_o,
  output logic                           vrf_req_o,
  output logic [AddrWidth-1:0]           vrf_addr_o,
  output logic [IdWidth-1:0]             vrf_id_o,
  output logic [DataWidth-1:0]           vrf_wdata_o,
  output logic [StrbWidth-1:0]           vrf_be_o,
  input  logic                           vrf_gnt_i,
`ifdef ARA_WB_ARB_PERF_EN
  output logic [NrSrc*32-1:0]            perf_grant_cnt_o,
  output logic [31:0]                    perf_stall_cnt_o,
`endif
  input  logic                           flush_i
);

  localparam int PtrW = (NrSrc > 1) ? $clog2(NrSrc) : 1;

  logic            full_q;
  logic [PtrW-1:0] rr_q;
  logic [PtrW-1:0] win;
  logic            any_gnt;
  logic            slot_free;
  int              idx;

  assign slot_free = !full_q || vrf_gnt_i;
  assign vrf_req_o = full_q;

  // Scan sources starting at the pointer, wrapping; first requester wins.
  always_comb begin
    win       = '0;
    any_gnt   = 1'b0;
    idx       = 0;
    src_gnt_o = '0;
    if (slot_free && !flush_i && !rst_i) begin
      for (int k = 0; k < NrSrc; k++) begin
        idx = (int'(rr_q) + k) % NrSrc;
        if (!any_gnt && src_req_i[idx]) begin
          any_gnt = 1'b1;
          win     = PtrW'(idx);
        end
      end
    end
    if (any_gnt) src_gnt_o[win] = 1'b1;
  end

  // Flush has priority: the write in the slot is dropped, and since no grant
  // was issued this cycle nothing refills it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q      <= 1'b0;
      rr_q        <= '0;
      vrf_addr_o  <= '0;
      vrf_id_o    <= '0;
      vrf_wdata_o <= '0;
      vrf_be_o    <= '0;
    end else if (flush_i) begin
      full_q <= 1'b0;
    end else if (any_gnt) begin
      full_q      <= 1'b1;
      rr_q        <= (win == PtrW'(NrSrc-1)) ? '0 : win + PtrW'(1);
      vrf_addr_o  <= src_addr_i [win*AddrWidth +: AddrWidth];
      vrf_id_o    <= src_id_i   [win*IdWidth   +: IdWidth];
      vrf_wdata_o <= src_wdata_i[win*DataWidth +: DataWidth];
      vrf_be_o    <= src_be_i   [win*StrbWidth +: StrbWidth];
    end else if (vrf_gnt_i) begin
      full_q <= 1'b0;
    end
  end

`ifdef ARA_WB_ARB_PERF_EN
  logic [NrSrc-1:0][31:0] grant_cnt_q;
  logic [31:0]            stall_cnt_q;

  for (genvar s = 0; s < NrSrc; s++) begin : g_gcnt
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                    grant_cnt_q[s] <= '0;
      else if (src_gnt_o[s] && grant_cnt_q[s] != '1) grant_cnt_q[s] <= grant_cnt_q[s] + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                           stall_cnt_q <= '0;
    else if (full_q && !vrf_gnt_i && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign perf_grant_cnt_o = grant_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  for (genvar s = 0; s < NrSrc; s++) begin : g_proto
    a_req_held : assert property (@(posedge clk_i) disable iff (rst_i)
      src_req_i[s] && !src_gnt_o[s] |=> src_req_i[s])
      else $error("src %0d dropped req without gnt", s);
    a_fields_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      src_req_i[s] && !src_gnt_o[s] |=>
        $stable(src_addr_i [s*AddrWidth +: AddrWidth]) &&
        $stable(src_id_i   [s*IdWidth   +: IdWidth])   &&
        $stable(src_wdata_i[s*DataWidth +: DataWidth]) &&
        $stable(src_be_i   [s*StrbWidth +: StrbWidth]))
      else $error("src %0d changed fields while waiting", s);
  end
  a_vrf_gnt : assert property (@(posedge clk_i) disable iff (rst_i)
    vrf_gnt_i |-> vrf_req_o)
    else $error("vrf_gnt_i without vrf_req_o");
`endif

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
module tb_vrf_wb_arbiter;
  localparam int N = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [N-1:0]  src_req_i = '0;
  logic [N*10-1:0] src_addr_i = '0;
  logic [N*3-1:0]  src_id_i = '0;
  logic [N*64-1:0] src_wdata_i = '0;
  logic [N*8-1:0]  src_be_i = '0;
  logic [N-1:0]  src_gnt_o;
  logic          vrf_req_o;
  logic [9:0]    vrf_addr_o;
  logic [2:0]    vrf_id_o;
  logic [63:0]   vrf_wdata_o;
  logic [7:0]    vrf_be_o;
  logic          vrf_gnt_i = 1'b0;
  logic          flush_i = 1'b0;
`ifdef ARA_WB_ARB_PERF_EN
  logic [N*32-1:0] perf_grant_cnt_o;
  logic [31:0]     perf_stall_cnt_o;
`endif

  vrf_wb_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .src_req_i(src_req_i), .src_addr_i(src_addr_i), .src_id_i(src_id_i),
    .src_wdata_i(src_wdata_i), .src_be_i(src_be_i), .src_gnt_o(src_gnt_o),
    .vrf_req_o(vrf_req_o), .vrf_addr_o(vrf_addr_o), .vrf_id_o(vrf_id_o),
    .vrf_wdata_o(vrf_wdata_o), .vrf_be_o(vrf_be_o), .vrf_gnt_i(vrf_gnt_i),
`ifdef ARA_WB_ARB_PERF_EN
    .perf_grant_cnt_o(perf_grant_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
    .flush_i(flush_i)
  );

  always #5 clk_i = ~clk_i;

  // source-side request state
  bit          req [N];
  logic [9:0]  s_addr [N];
  logic [2:0]  s_id [N];
  logic [63:0] s_data [N];
  logic [7:0]  s_be [N];

  // reference model: output slot contents and next-source pointer
  bit          m_full;
  int          m_rr;
  logic [9:0]  m_addr;
  logic [2:0]  m_id;
  logic [63:0] m_data;
  logic [7:0]  m_be;
  int          last_win;
  int          m_gcnt [N];
  int          m_stall;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_rr = 0; m_addr = '0; m_id = '0; m_data = '0; m_be = '0;
    m_stall = 0;
    for (int s = 0; s < N; s++) m_gcnt[s] = 0;
  endtask

  task automatic new_req(input int s, input logic [9:0] a, input logic [2:0] i,
                         input logic [63:0] d, input logic [7:0] b);
    req[s] = 1; s_addr[s] = a; s_id[s] = i; s_data[s] = d; s_be[s] = b;
  endtask

  // One cycle, entered and left at a negedge. Drives inputs, checks the
  // combinational grant and registered outputs, then advances the model.
  task automatic cycle(input bit vg, input bit fl);
    int win;
    bit vgm;
    vgm = vg & m_full;
    for (int s = 0; s < N; s++) begin
      src_req_i[s]            = req[s];
      src_addr_i[s*10 +: 10]  = s_addr[s];
      src_id_i[s*3 +: 3]      = s_id[s];
      src_wdata_i[s*64 +: 64] = s_data[s];
      src_be_i[s*8 +: 8]      = s_be[s];
    end
    vrf_gnt_i = vgm;
    flush_i   = fl;
    #1;
    win = -1;
    if ((!m_full || vgm) && !fl)
      for (int k = 0; k < N; k++)
        if (win < 0 && req[(m_rr + k) % N]) win = (m_rr + k) % N;
    chk("gnt", 64'(src_gnt_o), (win < 0) ? 64'd0 : 64'(1) << win);
    chk("vrf_req", 64'(vrf_req_o), 64'(m_full));
    chk("addr", 64'(vrf_addr_o), 64'(m_addr));
    chk("id", 64'(vrf_id_o), 64'(m_id));
    chk("wdata", vrf_wdata_o, m_data);
    chk("be", 64'(vrf_be_o), 64'(m_be));
    if (m_full && !vgm) m_stall++;
    if (fl) m_full = 0;
    else if (win >= 0) begin
      m_full = 1; m_rr = (win + 1) % N; m_gcnt[win]++;
      m_addr = s_addr[win]; m_id = s_id[win]; m_data = s_data[win]; m_be = s_be[win];
    end else if (vgm) m_full = 0;
    last_win = win;
    if (win >= 0) req[win] = 0;
    @(negedge clk_i);
  endtask

  task automatic drain_all();
    int n;
    n = 0;
    while ((req[0] || req[1] || req[2] || m_full) && n < 20) begin
      cycle(1, 0);
      n++;
    end
    chk("drain_bound", 64'(n < 20), 64'd1);
  endtask

  initial begin
    logic [2:0] rr_seq [4];
    rr_seq[0] = 3'b001; rr_seq[1] = 3'b010; rr_seq[2] = 3'b100; rr_seq[3] = 3'b001;
    model_reset();
    for (int s = 0; s < N; s++) begin
      req[s] = 0; s_addr[s] = '0; s_id[s] = '0; s_data[s] = '0; s_be[s] = '0;
    end
    @(negedge clk_i);
    chk("rst_req", 64'(vrf_req_o), 64'd0);
    chk("rst_gnt", 64'(src_gnt_o), 64'd0);
    chk("rst_addr", 64'(vrf_addr_o), 64'd0);
    rst_i = 1'b0;

    // round-robin with all sources continuously requesting
    for (int s = 0; s < N; s++) new_req(s, 10'(16*s + 1), 3'(s), 64'(s + 100), 8'hF0);
    for (int c = 0; c < 4; c++) begin
      cycle(1, 0);
      chk("rr_seq", 64'(1) << last_win, 64'(rr_seq[c]));
      new_req(last_win, 10'(16*last_win + c + 2), 3'(c), 64'(c), 8'h0F);
    end

    // async reset mid-burst while the slot is full
    chk("pre_rst_full", 64'(vrf_req_o), 64'd1);
    #2 rst_i = 1'b1;
    #1 chk("async_rst_req", 64'(vrf_req_o), 64'd0);
    chk("async_rst_gnt", 64'(src_gnt_o), 64'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    cycle(1, 0);
    chk("post_rst_src0", 64'(last_win), 64'd0);
    drain_all();

    // backpressure: src 1 stalled for 4 cycles, src 2 waits
    new_req(1, 10'h2A, 3'd1, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    cycle(0, 0);
    chk("bp_win1", 64'(last_win), 64'd1);
    new_req(2, 10'h3C, 3'd2, 64'h1234, 8'h03);
    for (int c = 0; c < 4; c++) begin
      cycle(0, 0);
      chk("bp_nogrant", 64'(last_win), -64'sd1);
      chk("bp_addr", 64'(vrf_addr_o), 64'h2A);
    end
    // drain + refill in the same cycle
    cycle(1, 0);
    chk("refill_src2", 64'(last_win), 64'd2);
    // flush overrides a simultaneous vrf_gnt_i and suppresses the grant
    new_req(0, 10'h11, 3'd5, 64'h55, 8'h01);
    chk("pre_flush_data", vrf_wdata_o, 64'h1234);
    cycle(1, 1);
    chk("flush_nogrant", 64'(last_win), -64'sd1);
    cycle(1, 0);
    chk("post_flush_src0", 64'(last_win), 64'd0);
    drain_all();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int s = 0; s < N; s++)
        if (!req[s] && ($urandom % 2 == 0))
          new_req(s, 10'($urandom), 3'($urandom), {$urandom, $urandom}, 8'($urandom));
      cycle($urandom % 4 != 0, $urandom % 16 == 0);
    end
    drain_all();

`ifdef ARA_WB_ARB_PERF_EN
    for (int s = 0; s < N; s++)
      chk("perf_grant", 64'(perf_grant_cnt_o[s*32 +: 32]), 64'(m_gcnt[s]));
    chk("perf_stall", 64'(perf_stall_cnt_o), 64'(m_stall));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
